// File: rtl/hilo_div_sequencer.sv
// hilo_div_sequencer: drives the multicycle divider's Div_Control window and
// owns the architectural HI/LO pair (capture, divide-by-zero, mthi/mtlo).
`default_nettype none

module hilo_div_sequencer #(
    parameter int DIV_LATENCY = 34,
    parameter int CNT_W       = 6
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic        Div_Control,
    input  logic        Div_Zero,
    input  logic [31:0] Div_HI,
    input  logic [31:0] Div_LO,
    input  logic        HI_Write,
    input  logic        LO_Write,
    input  logic [31:0] Write_Data,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done,
    output logic        Div_Exception
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIV_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] count;

    assign Busy = (state != IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            count         <= '0;
            Div_Control   <= 1'b0;
            HI            <= '0;
            LO            <= '0;
            Done          <= 1'b0;
            Div_Exception <= 1'b0;
        end else begin
            Done          <= 1'b0;
            Div_Exception <= 1'b0;
            case (state)
                IDLE: begin
                    // Architectural writes land even when a division starts in
                    // the same cycle; the later capture overwrites them.
                    if (HI_Write) HI <= Write_Data;
                    if (LO_Write) LO <= Write_Data;
                    if (Start) begin
                        state       <= RUN;
                        count       <= '0;
                        Div_Control <= 1'b1;
                    end
                end
                RUN: begin
                    if (Div_Zero) begin
                        state         <= IDLE;
                        count         <= '0;
                        Div_Control   <= 1'b0;
                        Div_Exception <= 1'b1;
                    end else if (count == LAST_COUNT) begin
                        // Done is raised for the capture cycle itself, when the
                        // divider outputs have settled.
                        state       <= CAPTURE;
                        count       <= '0;
                        Div_Control <= 1'b0;
                        Done        <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                CAPTURE: begin
                    HI    <= Div_HI;
                    LO    <= Div_LO;
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    count       <= '0;
                    Div_Control <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_sequencer.sv
// tb_hilo_div_sequencer: directed checks of the divider sequencer (default
// 34-cycle build and a 4-cycle build) with a tiny divider result model.
`default_nettype none

module tb_hilo_div_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        div_zero = 1'b0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = 32'd1;
    logic [31:0] div_hi, div_lo;

    logic        dc1, busy1, done1, exc1;
    logic [31:0] hi1, lo1;
    logic        dc2, busy2, done2, exc2;
    logic [31:0] hi2, lo2;

    int total = 0;
    int bad   = 0;

    assign div_hi = (op_b != 0) ? op_a % op_b : 32'd0;
    assign div_lo = (op_b != 0) ? op_a / op_b : 32'd0;

    always #5 clock = ~clock;

    hilo_div_sequencer dut (
        .Clock(clock), .Reset(reset), .Start(start), .Div_Control(dc1),
        .Div_Zero(div_zero), .Div_HI(div_hi), .Div_LO(div_lo),
        .HI_Write(hi_write), .LO_Write(lo_write), .Write_Data(write_data),
        .HI(hi1), .LO(lo1), .Busy(busy1), .Done(done1), .Div_Exception(exc1)
    );

    hilo_div_sequencer #(.DIV_LATENCY(4), .CNT_W(3)) dut4 (
        .Clock(clock), .Reset(reset), .Start(start2), .Div_Control(dc2),
        .Div_Zero(div_zero), .Div_HI(div_hi), .Div_LO(div_lo),
        .HI_Write(hi_write), .LO_Write(lo_write), .Write_Data(write_data),
        .HI(hi2), .LO(lo2), .Busy(busy2), .Done(done2), .Div_Exception(exc2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call in the first cycle after the Start edge; returns per-window counts
    // and stops on the first cycle Busy is low.
    task automatic wait_idle(input bit sel, output int busy_n, output int dc_n,
                             output int done_n, output int done_at);
        bit finished = 0;
        busy_n = 0; dc_n = 0; done_n = 0; done_at = 0;
        for (int i = 1; i <= 200; i++) begin
            if (!(sel ? busy2 : busy1)) begin
                finished = 1;
                break;
            end
            busy_n++;
            if (sel ? dc2 : dc1) dc_n++;
            if (sel ? done2 : done1) begin
                done_n++;
                done_at = i;
            end
            step();
        end
        check("timeout", 32'(finished), 32'd1);
    endtask

    initial begin
        int bn, dn, don, dat, idle_n, restarts;
        logic prev_busy;

        // Reset state
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_hi", hi1, 32'd0);
        check("rst_lo", lo1, 32'd0);
        check("rst_flags", {28'd0, dc1, busy1, done1, exc1}, 32'd0);

        // 8 / 5 -> HI=3, LO=1
        op_a = 32'd8; op_b = 32'd5;
        start = 1'b1; step(); start = 1'b0;
        check("run_dc_on", 32'(dc1), 32'd1);
        wait_idle(0, bn, dn, don, dat);
        check("t1_busy_cycles", bn, 32'd35);
        check("t1_dc_cycles", dn, 32'd34);
        check("t1_done_count", don, 32'd1);
        check("t1_done_cycle", dat, 32'd35);
        check("t1_hi", hi1, 32'd3);
        check("t1_lo", lo1, 32'd1);

        // Divide by zero on second RUN cycle
        op_b = 32'd0;
        start = 1'b1; step(); start = 1'b0;
        step();
        div_zero = 1'b1; step(); div_zero = 1'b0;
        check("dz_exc", 32'(exc1), 32'd1);
        check("dz_done", 32'(done1), 32'd0);
        check("dz_busy", 32'(busy1), 32'd0);
        check("dz_dc", 32'(dc1), 32'd0);
        step();
        check("dz_exc_pulse", 32'(exc1), 32'd0);
        check("dz_hi", hi1, 32'd3);
        check("dz_lo", lo1, 32'd1);

        // Start held 40 cycles: 6 / 2 -> HI=0, LO=3
        op_a = 32'd6; op_b = 32'd2;
        start = 1'b1;
        don = 0; idle_n = 0; restarts = 0; prev_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done1) don++;
            if (!busy1) idle_n++;
            if (busy1 && !prev_busy) restarts++;
            prev_busy = busy1;
        end
        start = 1'b0;
        check("t3_done_count", don, 32'd1);
        check("t3_idle_cycles", idle_n, 32'd1);
        check("t3_starts", restarts, 32'd2);
        wait_idle(0, bn, dn, don, dat);
        check("t3_hi", hi1, 32'd0);
        check("t3_lo", lo1, 32'd3);

        // mthi in IDLE, then dropped while Busy
        hi_write = 1'b1; write_data = 32'hDEADBEEF; step(); hi_write = 1'b0;
        check("mthi_hi", hi1, 32'hDEADBEEF);
        check("mthi_lo", lo1, 32'd3);
        start = 1'b1; step(); start = 1'b0;
        hi_write = 1'b1; lo_write = 1'b1; write_data = 32'h12345678; step();
        hi_write = 1'b0; lo_write = 1'b0;
        check("busy_write_hi", hi1, 32'hDEADBEEF);
        check("busy_write_lo", lo1, 32'd3);
        wait_idle(0, bn, dn, don, dat);

        // Start with both writes in IDLE: writes land, capture overwrites
        op_a = 32'd17; op_b = 32'd4;
        start = 1'b1; hi_write = 1'b1; lo_write = 1'b1; write_data = 32'hA5A5A5A5;
        step();
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        check("sw_hi", hi1, 32'hA5A5A5A5);
        check("sw_lo", lo1, 32'hA5A5A5A5);
        check("sw_busy", 32'(busy1), 32'd1);
        wait_idle(0, bn, dn, don, dat);
        check("sw_cap_hi", hi1, 32'd1);
        check("sw_cap_lo", lo1, 32'd4);

        // Reset on RUN cycle 10
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_hi", hi1, 32'd0);
        check("mid_rst_lo", lo1, 32'd0);
        check("mid_rst_dc", 32'(dc1), 32'd0);
        check("mid_rst_busy", 32'(busy1), 32'd0);
        op_a = 32'd8; op_b = 32'd5;
        start = 1'b1; step(); start = 1'b0;
        wait_idle(0, bn, dn, don, dat);
        check("post_rst_dc_cycles", dn, 32'd34);
        check("post_rst_hi", hi1, 32'd3);

        // DIV_LATENCY=4 build, back-to-back start
        op_a = 32'd9; op_b = 32'd2;
        start2 = 1'b1; step(); start2 = 1'b0;
        wait_idle(1, bn, dn, don, dat);
        check("l4_dc_cycles", dn, 32'd4);
        check("l4_done_cycle", dat, 32'd5);
        check("l4_done_count", don, 32'd1);
        check("l4_hi", hi2, 32'd1);
        check("l4_lo", lo2, 32'd4);
        op_a = 32'd7; op_b = 32'd7;
        start2 = 1'b1; step(); start2 = 1'b0;
        check("l4_b2b_busy", 32'(busy2), 32'd1);
        check("l4_b2b_dc", 32'(dc2), 32'd1);
        wait_idle(1, bn, dn, don, dat);
        check("l4_b2b_dc_cycles", dn, 32'd4);
        check("l4_b2b_hi", hi2, 32'd0);
        check("l4_b2b_lo", lo2, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Done and Div_Exception must never coincide
    always @(negedge clock) begin
        if ((done1 && exc1) || (done2 && exc2)) begin
            bad++;
            total++;
            $display("FAIL done_exc_overlap: got 1 expected 0");
        end
    end

endmodule

`default_nettype wire
